// File: rtl/mod11_pkg.sv
// mod11_pkg: definitions shared by the mod-11 counter and its monitor.
//   MOD11_MOD / MOD11_CNT_W : default modulus and count bus width.
//   mon_state_e             : monitor FSM states (IDLE, SYNC, TRACK).
//   next_mod()              : wrapped increment (MOD-1 -> 0, otherwise +1),
//                             kept here so the counter and the monitor
//                             cannot disagree on what the next count is.
package mod11_pkg;

    localparam int MOD11_MOD   = 11;
    localparam int MOD11_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2
    } mon_state_e;

    // Only the exact terminal value wraps; out-of-range counts simply
    // increment so a broken counter keeps producing a predictable value.
    function automatic logic [MOD11_CNT_W-1:0] next_mod(
        input logic [MOD11_CNT_W-1:0] cnt,
        input int                     mod
    );
        if (int'(cnt) == mod - 1) begin
            return '0;
        end
        return cnt + 1'b1;
    endfunction

endpackage

// File: rtl/mod11_predict.sv
// mod11_predict: prediction of the counter's next output.
//   clk, rst           : clock and synchronous active-low reset.
//   dut_rst_in         : counter reset (highest priority, predicts 0).
//   load_en_in/load_in : counter load (predicts load_in, even if out of range).
//   cnt_in             : currently observed count.
//   exp                : registered prediction for the next observed count.
module mod11_predict
    import mod11_pkg::*;
#(
    parameter int MOD   = MOD11_MOD,
    parameter int CNT_W = MOD11_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dut_rst_in,
    input  logic             load_en_in,
    input  logic [CNT_W-1:0] load_in,
    input  logic [CNT_W-1:0] cnt_in,
    output logic [CNT_W-1:0] exp
);

    logic [CNT_W-1:0] exp_reg;
    logic [CNT_W-1:0] exp_next;

    always_comb begin
        exp_next = '0;
        if (dut_rst_in) begin
            exp_next = '0;
        end else if (load_en_in) begin
            exp_next = load_in;
        end else begin
            exp_next = CNT_W'(next_mod(MOD11_CNT_W'(cnt_in), MOD));
        end
    end

    // The prediction runs every cycle regardless of monitor state, so it is
    // already valid on the first TRACK compare after SYNC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            exp_reg <= '0;
        end else begin
            exp_reg <= exp_next;
        end
    end

    assign exp = exp_reg;

endmodule

// File: rtl/mod11_monitor.sv
// mod11_monitor: passive checker for a mod-MOD counter.
//   clk, rst           : clock and synchronous active-low reset of the monitor.
//   dut_rst_in         : copy of the counter's active-high reset.
//   cnt_in             : observed counter output.
//   load_in/load_en_in : load stimulus presented to the counter.
//   mon_en             : monitoring enable; low returns to IDLE, stats held.
//   synced             : high while tracking the counter.
//   err                : one-cycle pulse on prediction mismatch.
//   illegal            : one-cycle pulse on out-of-range count or load value.
//   tc                 : one-cycle pulse after cnt_in==MOD-1 seen while tracking.
//   err_cnt            : saturating mismatch count.
//   wrap_cnt           : rolling count of observed MOD-1 -> 0 transitions.
module mod11_monitor
    import mod11_pkg::*;
#(
    parameter int MOD    = MOD11_MOD,
    parameter int CNT_W  = MOD11_CNT_W,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dut_rst_in,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic [CNT_W-1:0]  load_in,
    input  logic              load_en_in,
    input  logic              mon_en,
    output logic              synced,
    output logic              err,
    output logic              illegal,
    output logic              tc,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [1:0]       S_IDLE  = 2'(IDLE);
    localparam logic [1:0]       S_SYNC  = 2'(SYNC);
    localparam logic [1:0]       S_TRACK = 2'(TRACK);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(MOD - 1);

    logic [CNT_W-1:0]  exp;

    logic [1:0]        state_reg,    state_next;
    logic              synced_reg,   synced_next;
    logic              err_reg,      err_next;
    logic              illegal_reg,  illegal_next;
    logic              tc_reg,       tc_next;
    logic [ERR_W-1:0]  err_cnt_reg,  err_cnt_next;
    logic [WRAP_W-1:0] wrap_cnt_reg, wrap_cnt_next;
    logic [CNT_W-1:0]  prev_cnt_reg;
    logic              prev_ctl_reg;

    logic              active;
    logic              in_track;
    logic              mismatch;
    logic              wrap_hit;

    mod11_predict #(
        .MOD   (MOD),
        .CNT_W (CNT_W)
    ) u_predict (
        .clk        (clk),
        .rst        (rst),
        .dut_rst_in (dut_rst_in),
        .load_en_in (load_en_in),
        .load_in    (load_in),
        .cnt_in     (cnt_in),
        .exp        (exp)
    );

    always_comb begin
        active        = mon_en && (state_reg != S_IDLE);
        in_track      = mon_en && (state_reg == S_TRACK);
        mismatch      = in_track && (cnt_in != exp);
        // A wrap only counts when the counter got there by itself; a load or
        // reset on the previous edge could fake the 10 -> 0 pattern.
        wrap_hit      = in_track && (prev_cnt_reg == LAST) && (cnt_in == '0)
                        && !prev_ctl_reg;

        state_next    = state_reg;
        err_next      = mismatch;
        illegal_next  = active && ((cnt_in > LAST) || (load_en_in && (load_in > LAST)));
        tc_next       = in_track && (cnt_in == LAST);
        err_cnt_next  = err_cnt_reg;
        wrap_cnt_next = wrap_cnt_reg;

        if (mismatch && (err_cnt_reg != '1)) begin
            err_cnt_next = err_cnt_reg + 1'b1;
        end
        if (wrap_hit) begin
            wrap_cnt_next = wrap_cnt_reg + 1'b1;
        end

        if (!mon_en) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  state_next = S_SYNC;
                S_SYNC:  state_next = S_TRACK;
                S_TRACK: state_next = mismatch ? S_SYNC : S_TRACK;
                default: state_next = S_IDLE;
            endcase
        end

        synced_next = (state_next == S_TRACK);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            synced_reg   <= 1'b0;
            err_reg      <= 1'b0;
            illegal_reg  <= 1'b0;
            tc_reg       <= 1'b0;
            err_cnt_reg  <= '0;
            wrap_cnt_reg <= '0;
            prev_cnt_reg <= '0;
            prev_ctl_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            synced_reg   <= synced_next;
            err_reg      <= err_next;
            illegal_reg  <= illegal_next;
            tc_reg       <= tc_next;
            err_cnt_reg  <= err_cnt_next;
            wrap_cnt_reg <= wrap_cnt_next;
            prev_cnt_reg <= cnt_in;
            prev_ctl_reg <= dut_rst_in || load_en_in;
        end
    end

    assign synced   = synced_reg;
    assign err      = err_reg;
    assign illegal  = illegal_reg;
    assign tc       = tc_reg;
    assign err_cnt  = err_cnt_reg;
    assign wrap_cnt = wrap_cnt_reg;

endmodule

// File: tb/tb_mod11_monitor.sv
module tb_mod11_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       dut_rst_in;
    logic [3:0] cnt_in;
    logic [3:0] load_in;
    logic       load_en_in;
    logic       mon_en;
    logic       synced;
    logic       err;
    logic       illegal;
    logic       tc;
    logic [7:0] err_cnt;
    logic [7:0] wrap_cnt;

    mod11_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .dut_rst_in (dut_rst_in),
        .cnt_in     (cnt_in),
        .load_in    (load_in),
        .load_en_in (load_en_in),
        .mon_en     (mon_en),
        .synced     (synced),
        .err        (err),
        .illegal    (illegal),
        .tc         (tc),
        .err_cnt    (err_cnt),
        .wrap_cnt   (wrap_cnt)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int tc_seen = 0;
    bit me = 1'b1;
    int ctr = 0;

    // Reference model: mode 0=idle, 1=syncing, 2=tracking.
    int m_mode = 0;
    int m_exp = 0, m_prev = 0, m_prev_ctl = 0;
    int m_synced = 0, m_err = 0, m_ill = 0, m_tc = 0, m_errc = 0, m_wrap = 0;

    task automatic chk(input string name, input int got, input int expv);
        total++;
        if (got == expv) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
    endtask

    task automatic model_step();
        int c, pred;
        c = int'(cnt_in);
        if (!rst) begin
            m_mode = 0; m_exp = 0; m_prev = 0; m_prev_ctl = 0;
            m_synced = 0; m_err = 0; m_ill = 0; m_tc = 0; m_errc = 0; m_wrap = 0;
            return;
        end
        if (dut_rst_in)      pred = 0;
        else if (load_en_in) pred = int'(load_in);
        else                 pred = (c == 10) ? 0 : (c + 1) % 16;
        m_err = 0; m_ill = 0; m_tc = 0;
        if (!mon_en) begin
            m_mode = 0;
        end else begin
            if (m_mode != 0)
                m_ill = (c >= 11 || (load_en_in && int'(load_in) >= 11)) ? 1 : 0;
            if (m_mode == 2) begin
                m_tc = (c == 10) ? 1 : 0;
                if (m_prev == 10 && c == 0 && m_prev_ctl == 0) m_wrap = (m_wrap + 1) % 256;
                if (c != m_exp) begin
                    m_err = 1;
                    if (m_errc < 255) m_errc++;
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                m_mode = 2;
            end else begin
                m_mode = 1;
            end
        end
        m_exp = pred;
        m_prev = c;
        m_prev_ctl = (dut_rst_in || load_en_in) ? 1 : 0;
        m_synced = (m_mode == 2) ? 1 : 0;
    endtask

    task automatic compare_all();
        chk("synced",   int'(synced),   m_synced);
        chk("err",      int'(err),      m_err);
        chk("illegal",  int'(illegal),  m_ill);
        chk("tc",       int'(tc),       m_tc);
        chk("err_cnt",  int'(err_cnt),  m_errc);
        chk("wrap_cnt", int'(wrap_cnt), m_wrap);
    endtask

    task automatic cyc(input bit r, input bit dr, input bit le, input int ld, input int c);
        rst = r; dut_rst_in = dr; load_en_in = le;
        load_in = 4'(ld); cnt_in = 4'(c); mon_en = me;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        tc_seen += int'(tc);
    endtask

    task automatic run_ctr(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 0, ctr);
            ctr = (ctr >= 10) ? 0 : ctr + 1;
        end
    endtask

    initial begin
        // Monitor reset
        me = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 0, 0);
        chk("rst_synced", int'(synced), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_wrap_cnt", int'(wrap_cnt), 0);
        $display("txn reset: synced=%0d err_cnt=%0d wrap_cnt=%0d", synced, err_cnt, wrap_cnt);

        // Free run: 24 edges = 2 setup edges + 22 TRACK edges
        ctr = 0; tc_seen = 0;
        run_ctr(24);
        chk("free_wrap", int'(wrap_cnt), 2);
        chk("free_tc_pulses", tc_seen, 2);
        chk("free_err_cnt", int'(err_cnt), 0);
        $display("txn free_run: wrap_cnt=%0d tc_pulses=%0d err_cnt=%0d", wrap_cnt, tc_seen, err_cnt);

        // Load 7 at count 3, counter follows
        run_ctr(1);
        cyc(1'b1, 1'b0, 1'b1, 7, ctr);
        ctr = 7;
        run_ctr(6);
        chk("load_wrap", int'(wrap_cnt), 3);
        chk("load_err_cnt", int'(err_cnt), 0);
        $display("txn load7: wrap_cnt=%0d err_cnt=%0d", wrap_cnt, err_cnt);

        // Stuck count: hold 4 one extra cycle
        while (ctr != 4) run_ctr(1);
        cyc(1'b1, 1'b0, 1'b0, 0, ctr);
        run_ctr(1);
        chk("stuck_err", int'(err), 1);
        chk("stuck_synced", int'(synced), 0);
        chk("stuck_err_cnt", int'(err_cnt), 1);
        run_ctr(1);
        chk("stuck_resync", int'(synced), 1);
        run_ctr(4);
        chk("stuck_err_cnt_after", int'(err_cnt), 1);
        $display("txn stuck4: err_cnt=%0d synced=%0d", err_cnt, synced);

        // Illegal load value, counter ignores it
        cyc(1'b1, 1'b0, 1'b1, 12, ctr);
        ctr = (ctr >= 10) ? 0 : ctr + 1;
        chk("ill_load", int'(illegal), 1);
        run_ctr(4);
        cyc(1'b1, 1'b0, 1'b0, 0, 13);
        chk("ill_cnt", int'(illegal), 1);
        chk("ill_cnt_err", int'(err), 1);
        run_ctr(4);
        $display("txn illegal: err_cnt=%0d", err_cnt);

        // Saturation: constant count gives a mismatch every other cycle
        for (int i = 0; i < 620; i++) cyc(1'b1, 1'b0, 1'b0, 0, 5);
        chk("sat_err_cnt", int'(err_cnt), 255);
        $display("txn saturate: err_cnt=%0d", err_cnt);

        // Counter reset with simultaneous load at count 6
        ctr = 0;
        run_ctr(3);
        while (ctr != 6) run_ctr(1);
        cyc(1'b1, 1'b1, 1'b1, 2, 6);
        ctr = 0;
        run_ctr(1);
        chk("dutrst_err", int'(err), 0);
        chk("dutrst_synced", int'(synced), 1);
        $display("txn dut_rst: err=%0d synced=%0d", err, synced);

        // Monitor reset while tracking
        cyc(1'b0, 1'b0, 1'b0, 0, ctr);
        chk("midrst_synced", int'(synced), 0);
        chk("midrst_err_cnt", int'(err_cnt), 0);
        chk("midrst_wrap", int'(wrap_cnt), 0);
        $display("txn mid_reset: synced=%0d err_cnt=%0d wrap_cnt=%0d", synced, err_cnt, wrap_cnt);

        // mon_en drop: idle with held statistics
        ctr = 0;
        run_ctr(15);
        me = 1'b0;
        run_ctr(3);
        chk("drop_synced", int'(synced), 0);
        chk("drop_wrap", int'(wrap_cnt), 1);
        me = 1'b1;
        $display("txn mon_en_drop: synced=%0d wrap_cnt=%0d", synced, wrap_cnt);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            int ld;
            r = $urandom_range(0, 99);
            if (r < 5 && r >= 2) me = ~me;
            if (r < 2) begin
                cyc(1'b0, 1'b0, 1'b0, 0, ctr);
                ctr = 0;
            end else if (r < 8) begin
                cyc(1'b1, 1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 15), ctr);
                ctr = 0;
            end else if (r < 14) begin
                ld = (r < 13) ? $urandom_range(0, 10) : $urandom_range(11, 15);
                cyc(1'b1, 1'b0, 1'b1, ld, ctr);
                ctr = ld;
            end else if (r < 18) begin
                cyc(1'b1, 1'b0, 1'b0, 0, $urandom_range(0, 15));
                ctr = (ctr >= 10) ? 0 : ctr + 1;
            end else begin
                cyc(1'b1, 1'b0, 1'b0, 0, ctr);
                ctr = (ctr >= 10) ? 0 : ctr + 1;
            end
        end
        $display("txn random: err_cnt=%0d wrap_cnt=%0d", err_cnt, wrap_cnt);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
